// File: rtl/cache_write_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_write_buffer_pkg
// Brief    : Shared widths, entry record and tag helpers for the write buffer.
// Revision : 1.0 - initial release
// ============================================================================
package cache_write_buffer_pkg;

  localparam int ADDR_W          = 10;
  localparam int BLOCK_W         = 128;
  localparam int OFFS_W          = 4;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;
  localparam int TAG_W           = ADDR_W - OFFS_W;

  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [BLOCK_W-1:0] block_t;

  typedef struct packed {
    tag_t   tag;
    block_t data;
    logic   valid;
  } entry_t;

  // Rebuild the block-aligned byte address from a stored tag.
  function automatic logic [ADDR_W-1:0] block_base(input tag_t tag);
    return {tag, {OFFS_W{1'b0}}};
  endfunction

endpackage

`ifndef CWB_BLOCK_TAG
`define CWB_BLOCK_TAG(addr) addr[cache_write_buffer_pkg::ADDR_W-1:cache_write_buffer_pkg::OFFS_W]
`endif

`default_nettype wire

// File: rtl/cache_write_buffer_wb_match_select.sv
`default_nettype none
// ============================================================================
// Module   : wb_match_select
// Brief    : Tag match over all queued entries; youngest hit relative to wr_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module wb_match_select #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  parameter int PTR_W = 2
) (
  input  logic [TAG_W-1:0] tags [DEPTH],
  input  logic [DEPTH-1:0] valids,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output logic [PTR_W-1:0] hit_idx
);

  logic [DEPTH-1:0] w_match;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
      assign w_match[i] = valids[i] && (tags[i] == lookup_tag);
    end
  endgenerate

  // Walk from oldest slot (age DEPTH) to newest (age 1); the last match seen wins.
  always_comb begin : p_select
    logic [PTR_W-1:0] idx;
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr - PTR_W'(k);
      if (w_match[idx]) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cache_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cache_write_buffer
// Brief    : In-order block write buffer between L1 and memory with read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module cache_write_buffer
  import cache_write_buffer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = cache_write_buffer_pkg::ADDR_W,
  parameter int BLOCK_W = cache_write_buffer_pkg::BLOCK_W,
  parameter int OFFS_W  = cache_write_buffer_pkg::OFFS_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [BLOCK_W-1:0]       in_data,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [BLOCK_W-1:0]       mem_data,
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     lookup_hit,
  output logic [BLOCK_W-1:0]       lookup_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  entry_t               r_entries [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  tag_t                 w_tags [DEPTH];
  logic [DEPTH-1:0]     w_valids;
  logic                 w_hit;
  logic [c_PTR_W-1:0]   w_hit_idx;
  logic                 w_unused_offs;

  // Byte-offset bits never take part in matching or storage.
  assign w_unused_offs = ^{in_addr[OFFS_W-1:0], lookup_addr[OFFS_W-1:0]};

  assign w_full  = (r_count == c_CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Acceptance looks only at registered occupancy: a full buffer refuses
  // even when the head is leaving in the same cycle.
  assign in_ready  = !w_full;
  assign mem_valid = !w_empty;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = mem_valid && mem_ready;

  assign count = r_count;
  assign empty = w_empty;
  assign full  = w_full;

  assign mem_addr = w_empty ? '0 : block_base(r_entries[r_rd_ptr].tag);
  assign mem_data = w_empty ? '0 : r_entries[r_rd_ptr].data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i].valid <= 1'b0;
      end
    end else begin
      if (w_pop) begin
        r_entries[r_rd_ptr].valid <= 1'b0;
        r_rd_ptr                  <= r_rd_ptr + 1'b1;
      end
      // Push and pop never address the same slot: push needs !full, pop needs !empty.
      if (w_push) begin
        r_entries[r_wr_ptr].tag   <= `CWB_BLOCK_TAG(in_addr);
        r_entries[r_wr_ptr].data  <= in_data;
        r_entries[r_wr_ptr].valid <= 1'b1;
        r_wr_ptr                  <= r_wr_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
      assign w_tags[i]   = r_entries[i].tag;
      assign w_valids[i] = r_entries[i].valid;
    end
  endgenerate

  wb_match_select #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .PTR_W (c_PTR_W)
  ) u_match (
    .tags       (w_tags),
    .valids     (w_valids),
    .wr_ptr     (r_wr_ptr),
    .lookup_tag (`CWB_BLOCK_TAG(lookup_addr)),
    .hit        (w_hit),
    .hit_idx    (w_hit_idx)
  );

  assign lookup_hit  = w_hit;
  assign lookup_data = w_hit ? r_entries[w_hit_idx].data : '0;

endmodule

`default_nettype wire

// File: tb/tb_cache_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_write_buffer
// Brief    : Directed scenarios plus randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_write_buffer;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [9:0]   in_addr;
  logic [127:0] in_data;
  logic         mem_valid;
  logic         mem_ready;
  logic [9:0]   mem_addr;
  logic [127:0] mem_data;
  logic [9:0]   lookup_addr;
  logic         lookup_hit;
  logic [127:0] lookup_data;
  logic [2:0]   count;
  logic         empty;
  logic         full;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [9:0]   a;
    logic [127:0] d;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  cache_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .count       (count),
    .empty       (empty),
    .full        (full)
  );

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance one clock; the model applies the queue rules to the current inputs.
  task automatic tick();
    bit pu, po;
    pu = in_valid && (q.size() < DEPTH);
    po = mem_ready && (q.size() > 0);
    @(posedge clk);
    if (reset) q.delete();
    else begin
      if (po) void'(q.pop_front());
      if (pu) q.push_back('{in_addr, in_data});
    end
    #1;
  endtask

  // Youngest queued entry with the same block tag.
  function automatic void ref_lookup(input logic [9:0] a, output bit h, output logic [127:0] d);
    h = 0; d = '0;
    foreach (q[i]) if (q[i].a[9:4] == a[9:4]) begin h = 1; d = q[i].d; end
  endfunction

  task automatic push(input logic [9:0] a, input logic [127:0] d);
    in_valid = 1; in_addr = a; in_data = d;
    tick();
    in_valid = 0;
  endtask

  task automatic drain();
    mem_ready = 1;
    for (int i = 0; i < 8 && q.size() > 0; i++) tick();
    mem_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; mem_ready = 0; in_addr = '0; in_data = '0; lookup_addr = '0;
    tick(); tick();
    reset = 0;
    n_vec++;
    if ({empty, mem_valid, in_ready, count, full} !== {1'b1, 1'b0, 1'b1, 3'd0, 1'b0}) begin
      n_err++; $display("FAIL reset_flags: got e=%b mv=%b ir=%b cnt=%0d f=%b", empty, mem_valid, in_ready, count, full);
    end
    n_vec++;
    if (mem_addr !== 10'h0 || mem_data !== 128'h0) begin
      n_err++; $display("FAIL reset_mem: got addr=%h data=%h exp 0", mem_addr, mem_data);
    end
    for (int i = 0; i < 4; i++) begin
      lookup_addr = 10'($urandom); #1;
      n_vec++;
      if (lookup_hit !== 1'b0 || lookup_data !== 128'h0) begin
        n_err++; $display("FAIL reset_lookup: addr=%h got hit=%b data=%h exp 0", lookup_addr, lookup_hit, lookup_data);
      end
    end
  endtask

  task automatic test_hold();
    logic [127:0] d;
    d = 128'h4444_3333_2222_1111;
    push(10'h0A4, d);
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (mem_valid !== 1'b1 || mem_addr !== 10'h0A0 || mem_data !== d || count !== 3'd1) begin
        n_err++; $display("FAIL hold[%0d]: got mv=%b addr=%h data=%h cnt=%0d exp 1/0a0/%h/1", i, mem_valid, mem_addr, mem_data, count, d);
      end
      tick();
    end
    drain();
    n_vec++;
    if (empty !== 1'b1 || mem_data !== 128'h0) begin
      n_err++; $display("FAIL hold_drain: got empty=%b data=%h exp 1/0", empty, mem_data);
    end
  endtask

  task automatic test_fill_drain(input int rounds);
    ent_t exp[4];
    for (int r = 0; r < rounds; r++) begin
      for (int i = 0; i < 4; i++) begin
        exp[i].a = {6'(8 * r + i + 1), 4'($urandom)};
        exp[i].d = rnd128();
        push(exp[i].a, exp[i].d);
      end
      n_vec++;
      if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
        n_err++; $display("FAIL fill_full: got f=%b ir=%b cnt=%0d exp 1/0/4", full, in_ready, count);
      end
      in_valid = 1; in_addr = 10'h3F0; in_data = rnd128(); mem_ready = 1;
      tick();
      in_valid = 0;
      n_vec++;
      if (count !== 3'd3 || mem_data !== exp[1].d) begin
        n_err++; $display("FAIL fill_refuse: got cnt=%0d data=%h exp 3/%h", count, mem_data, exp[1].d);
      end
      for (int i = 1; i < 4; i++) begin
        n_vec++;
        if (mem_addr !== {exp[i].a[9:4], 4'h0} || mem_data !== exp[i].d) begin
          n_err++; $display("FAIL drain_order[%0d]: got %h/%h exp %h/%h", i, mem_addr, mem_data, {exp[i].a[9:4], 4'h0}, exp[i].d);
        end
        tick();
      end
      mem_ready = 0;
      n_vec++;
      if (empty !== 1'b1 || mem_valid !== 1'b0) begin
        n_err++; $display("FAIL drain_empty: got e=%b mv=%b exp 1/0", empty, mem_valid);
      end
    end
  endtask

  task automatic test_lookup_youngest();
    logic [127:0] da, db;
    da = rnd128(); db = ~da;
    in_valid = 1; in_addr = 10'h0C0; in_data = da; lookup_addr = 10'h0C8; #1;
    n_vec++;
    if (lookup_hit !== 1'b0) begin
      n_err++; $display("FAIL lookup_inflight: got hit=%b exp 0", lookup_hit);
    end
    tick();
    push(10'h0CC, db);
    n_vec++;
    if (lookup_hit !== 1'b1 || lookup_data !== db) begin
      n_err++; $display("FAIL lookup_youngest: got hit=%b data=%h exp 1/%h", lookup_hit, lookup_data, db);
    end
    drain();
    n_vec++;
    if (lookup_hit !== 1'b0 || lookup_data !== 128'h0) begin
      n_err++; $display("FAIL lookup_drained: got hit=%b data=%h exp 0/0", lookup_hit, lookup_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d0, d1, d2;
    d0 = rnd128(); d1 = rnd128(); d2 = rnd128();
    push(10'h100, d0);
    push(10'h110, d1);
    in_valid = 1; in_addr = 10'h120; in_data = d2; mem_ready = 1;
    tick();
    in_valid = 0; mem_ready = 0;
    n_vec++;
    if (count !== 3'd2 || mem_data !== d1 || mem_addr !== 10'h110) begin
      n_err++; $display("FAIL simul: got cnt=%0d addr=%h data=%h exp 2/110/%h", count, mem_addr, mem_data, d1);
    end
    mem_ready = 1; tick(); mem_ready = 0;
    n_vec++;
    if (mem_data !== d2 || count !== 3'd1) begin
      n_err++; $display("FAIL simul_tail: got cnt=%0d data=%h exp 1/%h", count, mem_data, d2);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [127:0] d;
    for (int i = 0; i < 3; i++) push(10'(10'h200 + 16 * i), rnd128());
    reset = 1; mem_ready = 1; in_valid = 1; in_addr = 10'h240; in_data = rnd128();
    tick();
    reset = 0; mem_ready = 0; in_valid = 0; lookup_addr = 10'h210; #1;
    n_vec++;
    if (count !== 3'd0 || mem_valid !== 1'b0 || lookup_hit !== 1'b0) begin
      n_err++; $display("FAIL reset_mid: got cnt=%0d mv=%b hit=%b exp 0/0/0", count, mem_valid, lookup_hit);
    end
    d = rnd128();
    push(10'h35A, d);
    n_vec++;
    if (count !== 3'd1 || mem_addr !== 10'h350 || mem_data !== d) begin
      n_err++; $display("FAIL reset_repush: got cnt=%0d addr=%h data=%h exp 1/350/%h", count, mem_addr, mem_data, d);
    end
    drain();
  endtask

  task automatic test_random(input int cycles);
    bit           eh;
    logic [127:0] ed;
    logic [9:0]   ea;
    for (int c = 0; c < cycles; c++) begin
      reset       = ($urandom_range(0, 63) == 0);
      in_valid    = $urandom_range(0, 1);
      mem_ready   = ($urandom_range(0, 2) == 0);
      in_addr     = {6'($urandom_range(0, 5)), 4'($urandom)};
      in_data     = rnd128();
      lookup_addr = {6'($urandom_range(0, 5)), 4'($urandom)};
      #1;
      ref_lookup(lookup_addr, eh, ed);
      ea = (q.size() > 0) ? {q[0].a[9:4], 4'h0} : 10'h0;
      n_vec++;
      if (count !== 3'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)
          || in_ready !== (q.size() < DEPTH) || mem_valid !== (q.size() > 0)) begin
        n_err++; $display("FAIL rnd_flags[%0d]: got cnt=%0d e=%b f=%b ir=%b mv=%b exp cnt=%0d", c, count, empty, full, in_ready, mem_valid, q.size());
      end
      n_vec++;
      if (mem_addr !== ea || mem_data !== ((q.size() > 0) ? q[0].d : 128'h0)) begin
        n_err++; $display("FAIL rnd_head[%0d]: got addr=%h data=%h exp addr=%h", c, mem_addr, mem_data, ea);
      end
      n_vec++;
      if (lookup_hit !== eh || lookup_data !== ed) begin
        n_err++; $display("FAIL rnd_lookup[%0d]: addr=%h got %b/%h exp %b/%h", c, lookup_addr, lookup_hit, lookup_data, eh, ed);
      end
      tick();
    end
    reset = 0; in_valid = 0; mem_ready = 0;
  endtask

  initial begin
    test_reset();
    test_hold();
    test_fill_drain(2);
    test_lookup_youngest();
    test_back_to_back();
    test_reset_mid();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
